// File: rtl/trace_dec_ctrl.sv
// -----------------------------------------------------------------------------
// trace_dec_ctrl
//
// Capture controller for an emulation trace buffer. A free-running decimation
// counter produces a sample strobe every (emu_dec_thr + 1) cycles. A small FSM
// (IDLE -> ARMED -> CAPT -> DONE) gates that strobe into trace-memory writes.
// Each capture fills exactly 2^DEPTH_BITS consecutive addresses starting at 0.
//
// Build option:
//   TRACE_TRIG_EN  defined   : ARMED waits for trig before capturing.
//                  undefined : trig is ignored and ARMED moves to CAPT one
//                              cycle after entry.
//
// Ports:
//   emu_clk      in   1           emulation clock, rising edge
//   emu_rst      in   1           synchronous active-high reset
//   emu_dec_thr  in   DEC_BITS    decimation threshold
//   arm          in   1           single-cycle capture request
//   trig         in   1           capture trigger (level, ARMED only)
//   abort        in   1           single-cycle cancel, any state
//   emu_dec_cmp  out  1           decimated sample strobe (combinational)
//   wr_en        out  1           trace memory write enable
//   wr_addr      out  DEPTH_BITS  trace memory write address
//   busy         out  1           registered: ARMED or CAPT
//   done         out  1           registered: DONE
// -----------------------------------------------------------------------------
module trace_dec_ctrl #(
    parameter int DEC_BITS   = 8,
    parameter int DEPTH_BITS = 10
) (
    input  logic                  emu_clk,
    input  logic                  emu_rst,
    input  logic [DEC_BITS-1:0]   emu_dec_thr,
    input  logic                  arm,
    input  logic                  trig,
    input  logic                  abort,
    output logic                  emu_dec_cmp,
    output logic                  wr_en,
    output logic [DEPTH_BITS-1:0] wr_addr,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_CAPT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [DEC_BITS-1:0]   r_dec_cnt;
    logic [DEPTH_BITS-1:0] r_wr_addr;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_thr_hit;
    logic                  w_wr_en;
    logic                  w_last_addr;

    // Using >= rather than == means a threshold lowered below the running
    // count fires immediately and restarts, so the counter never wraps.
    assign w_thr_hit   = (r_dec_cnt >= emu_dec_thr);
    assign emu_dec_cmp = w_thr_hit & ~emu_rst;
    assign w_wr_en     = (r_state == ST_CAPT) & emu_dec_cmp & ~abort;
    assign w_last_addr = (r_wr_addr == {DEPTH_BITS{1'b1}});

    assign wr_en   = w_wr_en;
    assign wr_addr = r_wr_addr;
    assign busy    = r_busy;
    assign done    = r_done;

`ifndef TRACE_TRIG_EN
    // trig stays on the port list so both builds share one pinout.
    logic w_unused_trig;
    assign w_unused_trig = trig;
`endif

    // Decimation counter: free-runs in every FSM state.
    always_ff @(posedge emu_clk) begin
        if (emu_rst || w_thr_hit) begin
            r_dec_cnt <= '0;
        end else begin
            r_dec_cnt <= r_dec_cnt + DEC_BITS'(1);
        end
    end

    // Capture FSM. busy/done are assigned alongside each state change so they
    // are pure flop outputs with no path from arm/trig/abort.
    always_ff @(posedge emu_clk) begin
        if (emu_rst || abort) begin
            r_state   <= ST_IDLE;
            r_wr_addr <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        r_state   <= ST_ARMED;
                        r_wr_addr <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                ST_ARMED: begin
`ifdef TRACE_TRIG_EN
                    if (trig) begin
                        r_state <= ST_CAPT;
                        r_busy  <= 1'b1;
                    end
`else
                    r_state <= ST_CAPT;
                    r_busy  <= 1'b1;
`endif
                end
                ST_CAPT: begin
                    if (w_wr_en) begin
                        // Natural wrap returns the address to 0 after the
                        // final write.
                        r_wr_addr <= r_wr_addr + DEPTH_BITS'(1);
                        if (w_last_addr) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_dec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trace_dec_ctrl
//
// Directed bench for trace_dec_ctrl with DEPTH_BITS=4. Stimulus pushes the
// expected write stream (address and cycle relative to reset release) into a
// queue; an independent negedge monitor pops one entry per wr_en.
// Expected values depend on TRACE_TRIG_EN where the trigger changes timing.
// -----------------------------------------------------------------------------
module tb_trace_dec_ctrl;

    localparam int DB = 8;
    localparam int AB = 4;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          emu_rst = 1'b0;
    logic [DB-1:0] emu_dec_thr = '0;
    logic          arm = 1'b0;
    logic          trig = 1'b0;
    logic          abort = 1'b0;
    logic          emu_dec_cmp;
    logic          wr_en;
    logic [AB-1:0] wr_addr;
    logic          busy;
    logic          done;

    int cyc    = 0;
    int base   = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int addr;
        int cyc;
    } wr_exp_t;

    wr_exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    trace_dec_ctrl #(
        .DEC_BITS   (DB),
        .DEPTH_BITS (AB)
    ) dut (
        .emu_clk     (clk),
        .emu_rst     (emu_rst),
        .emu_dec_thr (emu_dec_thr),
        .arm         (arm),
        .trig        (trig),
        .abort       (abort),
        .emu_dec_cmp (emu_dec_cmp),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .busy        (busy),
        .done        (done)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0h required %0h", nm, cyc - base, act, exp);
        end
    endfunction

    task automatic push_wr(int a, int c);
        wr_exp_t e;
        e.addr = a;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Monitor: one line per write, compared against the scoreboard head.
    always @(negedge clk) begin
        wr_exp_t e;
        if (wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected cycle %0d actual addr %0d required no write",
                         cyc - base, wr_addr);
            end else begin
                e = sb.pop_front();
                $display("WR cycle %0d addr %0d (exp addr %0d cycle %0d)",
                         cyc - base, wr_addr, e.addr, e.cyc);
                chk("wr_addr", 32'(wr_addr), e.addr);
                chk("wr_cycle", cyc - base, e.cyc);
            end
        end
        if (emu_rst === 1'b1 && (wr_en !== 1'b0 || emu_dec_cmp !== 1'b0)) begin
            chk("rst_gating", {30'd0, wr_en, emu_dec_cmp}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(int c);
        while (cyc - base < c) tick();
    endtask

    // Two reset cycles; outputs checked while reset is held. Returns in the
    // first cycle after release with base marking that cycle as 0.
    task automatic do_reset();
        emu_rst = 1'b1;
        arm = 1'b0;
        trig = 1'b0;
        abort = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_cmp", 32'(emu_dec_cmp), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        tick();
        emu_rst = 1'b0;
        base = cyc;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cycle %0d actual running required finished", cyc - base);
        $fatal(1, "watchdog");
    end

    initial begin
        int cs;

        // thr=0: reset gates the strobe, then it fires in the first cycle.
        emu_dec_thr = 8'd0;
        do_reset();
        @(negedge clk);
        chk("thr0_first_strobe", 32'(emu_dec_cmp), 1);
        tick();
        @(negedge clk);
        chk("thr0_second_strobe", 32'(emu_dec_cmp), 1);

        // thr=3: strobe every 4th cycle; at cycle 10 (count=2) drop thr to 1.
        emu_dec_thr = 8'd3;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i >= 10) emu_dec_thr = 8'd1;
            @(negedge clk);
            if (i < 10) chk("dec_thr3", 32'(emu_dec_cmp), (i % 4 == 3) ? 1 : 0);
            else        chk("dec_thr1", 32'(emu_dec_cmp), (i % 2 == 0) ? 1 : 0);
            tick();
        end

        // thr=0 full capture, trig 3 cycles after arm; then abort in DONE.
        emu_dec_thr = 8'd0;
        do_reset();
`ifdef TRACE_TRIG_EN
        cs = 4;
`else
        cs = 2;
`endif
        for (int a = 0; a < NW; a++) push_wr(a, cs + a);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        @(negedge clk);
        chk("b_busy_armed", 32'(busy), 1);
        chk("b_done_armed", 32'(done), 0);
        goto_cyc(3);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        goto_cyc(cs + NW);
        @(negedge clk);
        chk("b_done", 32'(done), 1);
        chk("b_busy", 32'(busy), 0);
        chk("b_addr_wrap", 32'(wr_addr), 0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("b_abort_done", 32'(done), 0);
        chk("b_abort_busy", 32'(busy), 0);

        // thr=2 full capture: writes every 3rd cycle from cycle 2.
        emu_dec_thr = 8'd2;
        do_reset();
        for (int a = 0; a < NW; a++) push_wr(a, 2 + 3 * a);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        goto_cyc(47);
        @(negedge clk);
        chk("c_busy_last", 32'(busy), 1);
        chk("c_done_last", 32'(done), 0);
        tick();
        @(negedge clk);
        chk("c_done", 32'(done), 1);
        chk("c_busy", 32'(busy), 0);
        chk("c_addr_wrap", 32'(wr_addr), 0);

        // Abort at address 7, then a fresh capture from address 0.
        emu_dec_thr = 8'd0;
        do_reset();
        for (int a = 0; a < 7; a++) push_wr(a, 2 + a);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        goto_cyc(9);
        abort = 1'b1;
        @(negedge clk);
        chk("d_abort_wr_en", 32'(wr_en), 0);
        chk("d_abort_addr", 32'(wr_addr), 7);
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("d_idle_busy", 32'(busy), 0);
        chk("d_idle_done", 32'(done), 0);
        chk("d_idle_addr", 32'(wr_addr), 0);
        for (int a = 0; a < NW; a++) push_wr(a, 12 + a);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        goto_cyc(28);
        @(negedge clk);
        chk("d_done", 32'(done), 1);

        // arm+trig together, then reset pulsed mid-capture.
        emu_dec_thr = 8'd0;
        do_reset();
`ifdef TRACE_TRIG_EN
        cs = 5;
`else
        cs = 2;
`endif
        for (int a = 0; a < 5; a++) push_wr(a, cs + a);
        arm = 1'b1;
        trig = 1'b1;
        tick();
        arm = 1'b0;
        trig = 1'b0;
        @(negedge clk);
        chk("e_busy_armed", 32'(busy), 1);
        tick();
`ifdef TRACE_TRIG_EN
        goto_cyc(3);
        @(negedge clk);
        chk("e_still_armed", 32'(busy), 1);
        chk("e_no_capture", 32'(wr_en), 0);
        goto_cyc(4);
        trig = 1'b1;
        tick();
        trig = 1'b0;
`endif
        goto_cyc(cs + 5);
        emu_rst = 1'b1;
        @(negedge clk);
        chk("e_rst_cmp", 32'(emu_dec_cmp), 0);
        chk("e_rst_wr_en", 32'(wr_en), 0);
        tick();
        emu_rst = 1'b0;
        @(negedge clk);
        chk("e_post_busy", 32'(busy), 0);
        chk("e_post_done", 32'(done), 0);
        chk("e_post_addr", 32'(wr_addr), 0);
        repeat (4) tick();

        // thr=1, trig held low; a second arm during the capture is ignored.
        emu_dec_thr = 8'd1;
        do_reset();
`ifndef TRACE_TRIG_EN
        for (int a = 0; a < NW; a++) push_wr(a, 3 + 2 * a);
`endif
        arm = 1'b1;
        tick();
        arm = 1'b0;
        @(negedge clk);
        chk("f_busy_c1", 32'(busy), 1);
        tick();
        @(negedge clk);
        chk("f_busy_c2", 32'(busy), 1);
        goto_cyc(10);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        goto_cyc(34);
        @(negedge clk);
`ifdef TRACE_TRIG_EN
        chk("f_armed_busy", 32'(busy), 1);
        chk("f_armed_done", 32'(done), 0);
`else
        chk("f_done", 32'(done), 1);
        chk("f_busy", 32'(busy), 0);
        chk("f_addr_wrap", 32'(wr_addr), 0);
`endif
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();

        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_dec_ctrl.md
TRACE_DEC_CTRL -- requirements
Module: trace_dec_ctrl

Interface
REQ-001 Parameter DEC_BITS, default 8: width of the decimation threshold and counter; the top level drives it from `DEC_BITS_MSDSL.
REQ-002 Parameter DEPTH_BITS, default 10: trace memory address width; capture depth is 2^DEPTH_BITS samples.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 emu_clk  in  1  emulation clock; all state updates on its rising edge.
REQ-005 emu_rst  in  1  synchronous active-high reset.
REQ-006 emu_dec_thr  in  DEC_BITS  decimation threshold, driven by the VIO.
REQ-007 arm  in  1  single-cycle request to start a capture.
REQ-008 trig  in  1  capture trigger, level-sampled.
REQ-009 abort  in  1  single-cycle request to cancel the capture in progress.
REQ-010 emu_dec_cmp  out  1  decimated sample strobe.
REQ-011 wr_en  out  1  trace memory write enable.
REQ-012 wr_addr  out  DEPTH_BITS  trace memory write address.
REQ-013 busy  out  1  high in ARMED or CAPT.
REQ-014 done  out  1  high in DONE.

Function
REQ-015 Decimation counter dec_cnt (DEC_BITS): in any cycle with dec_cnt >= emu_dec_thr it loads 0 next cycle, otherwise it increments.
REQ-016 emu_dec_cmp is combinational: (dec_cnt >= emu_dec_thr) AND NOT emu_rst.
- thr=N, held constant: strobe period N+1 cycles.
- thr=0: strobe every cycle.
REQ-017 A threshold lowered below the current dec_cnt produces a strobe in that same cycle and restarts the count from 0; the counter never wraps through all-ones.
REQ-018 The counter free-runs in every FSM state.
REQ-019 FSM states and transitions:
- IDLE: arm -> ARMED.
- ARMED: trig -> CAPT.
- CAPT: write at the last address -> DONE.
- DONE: arm -> ARMED.
REQ-020 A trig sampled in the cycle in which ARMED is entered from IDLE, or in IDLE itself, is ignored; trig is only acted on in ARMED.
REQ-021 arm in ARMED or CAPT is ignored.
REQ-022 wr_en = (state==CAPT) AND emu_dec_cmp AND NOT abort; the first write is at the first strobe in or after the first CAPT cycle.
REQ-023 wr_addr increments by 1 after each write.
REQ-024 The write at address 2^DEPTH_BITS-1 wraps wr_addr to 0 and moves the FSM to DONE; exactly 2^DEPTH_BITS writes are made per capture.
REQ-025 Any transition into ARMED clears wr_addr to 0.
REQ-026 abort in any state -> IDLE next cycle and clears wr_addr to 0.
REQ-027 abort takes priority over arm, trig and completion in the same cycle.
REQ-028 busy and done are registered state decodes: no combinational path from arm, trig or abort.

Reset
REQ-029 While emu_rst is high:
- state <= IDLE, dec_cnt <= 0, wr_addr <= 0.
- emu_dec_cmp = 0, wr_en = 0, busy = 0, done = 0.
REQ-030 emu_rst asserted mid-capture discards the capture; no wr_en is produced in any cycle in which emu_rst is high.
REQ-031 The first strobe after reset release, with thr held, occurs in the first cycle after release if thr=0, otherwise thr cycles after release.

Configuration
REQ-032 Macro TRACE_TRIG_EN.
- Defined: ARMED waits for trig as in REQ-019.
- Undefined: the trig port remains present but is ignored, and ARMED -> CAPT unconditionally one cycle after entry.

Verification (DEPTH_BITS=4 unless stated)
REQ-033 Hold thr=3 from reset -> emu_dec_cmp high every 4th cycle; change thr 3->1 while dec_cnt=2 -> strobe in that same cycle, then every 2nd cycle.
REQ-034 thr=0, arm, trig 3 cycles later -> 16 consecutive wr_en with wr_addr 0..15, then done=1, busy=0, wr_addr=0.
REQ-035 thr=2, full capture -> wr_en only on strobe cycles, spaced 3 cycles apart; done asserted the cycle after the write at address 15.
REQ-036 abort at wr_addr=7 during CAPT -> wr_en=0 in the abort cycle, IDLE next cycle, wr_addr=0; a following arm+trig captures from address 0.
REQ-037 arm and trig in the same IDLE cycle -> ARMED only, no capture; a subsequent trig starts the capture; emu_rst pulsed mid-CAPT -> all outputs 0 and the FSM in IDLE.
REQ-038 TRACE_TRIG_EN undefined: arm with trig held 0 -> CAPT two cycles after arm and a full 16-write capture.
